// File: rtl/trace_capture_ctrl.sv
// Side-channel trace capture: pre/post-trigger circular buffer, dumped as a byte stream.
// Optional macro TRACE_MARKER_EN marks the cipher-complete cycle with 0xFF in every channel.
module trace_capture_ctrl #(
    parameter int CH    = 1,
    parameter int DEPTH = 1024,
    parameter int PRE   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arm,
    input  logic            trig,
    input  logic            done,
    input  logic [8*CH-1:0] sample_i,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    output logic            busy,
    output logic            overrun,
    output logic [1:0]      state_dbg
);
    // Byte handshake: a byte moves on any cycle with tx_valid && tx_ready; while
    // tx_valid is high and tx_ready low, tx_valid and tx_data hold their values.

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int BW  = $clog2(4 + DEPTH * CH + 1);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [BW-1:0]  TOTAL     = BW'(4 + DEPTH * CH);
    localparam logic [CW-1:0]  PRE_C     = CW'(PRE);
    localparam logic [CW-1:0]  POST_LAST = CW'(DEPTH - PRE - 1);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(CH - 1);
    localparam logic [15:0]    DEPTH16   = 16'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DUMP = 2'd3} state_t;

    state_t          state, next_state;
    logic [8*CH-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;
    logic [CW-1:0]   fill, cap_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [CHW-1:0]  ch_sel;
    logic            trig_ok, load, last_xfer, wr_en;
    logic [8*CH-1:0] wr_data, rd_word;
    logic [7:0]      hdr_byte, sample_byte;

    assign trig_ok   = trig && (fill == PRE_C);
    assign load      = (state == DUMP) && (!tx_valid || tx_ready) && (byte_cnt != TOTAL);
    assign last_xfer = (state == DUMP) && tx_valid && tx_ready && (byte_cnt == TOTAL);
    assign wr_en     = (state == ARMED) || (state == CAPTURE);
    assign rd_word   = mem[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arm) next_state = ARMED;
            ARMED:   if (trig_ok) next_state = (DEPTH - PRE == 1) ? DUMP : CAPTURE;
            CAPTURE: if (cap_cnt == POST_LAST) next_state = DUMP;
            DUMP:    if (last_xfer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

`ifdef TRACE_MARKER_EN
    always_comb begin
        wr_data = '0;
        for (int c = 0; c < CH; c++) begin
            if (state == CAPTURE && done)
                wr_data[8*c +: 8] = 8'hFF;
            else if (sample_i[8*c +: 8] == 8'hFF)
                wr_data[8*c +: 8] = 8'hFE;
            else
                wr_data[8*c +: 8] = sample_i[8*c +: 8];
        end
    end
`else
    logic unused_done;
    assign unused_done = done;
    assign wr_data     = sample_i;
`endif

    always_comb begin
        hdr_byte = 8'hA5;
        case (byte_cnt[1:0])
            2'd1:    hdr_byte = 8'(CH);
            2'd2:    hdr_byte = DEPTH16[15:8];
            2'd3:    hdr_byte = DEPTH16[7:0];
            default: hdr_byte = 8'hA5;
        endcase
        sample_byte = rd_word[7:0];
        for (int c = 0; c < CH; c++)
            if (ch_sel == CHW'(c)) sample_byte = rd_word[8*c +: 8];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= wr_data;
    end

    // After DEPTH-PRE post-trigger writes, ptr already points at the oldest
    // pre-trigger sample, so the dump reads forward from where capture stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            fill     <= '0;
            cap_cnt  <= '0;
            byte_cnt <= '0;
            ch_sel   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            overrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    fill     <= '0;
                    cap_cnt  <= '0;
                    byte_cnt <= '0;
                    ch_sel   <= '0;
                    overrun  <= 1'b0;
                end
                ARMED: begin
                    ptr <= ptr + 1'b1;
                    if (fill < PRE_C) fill <= fill + 1'b1;
                    if (trig_ok)   cap_cnt <= CW'(1);
                    else if (trig) overrun <= 1'b1;
                end
                CAPTURE: begin
                    ptr     <= ptr + 1'b1;
                    cap_cnt <= cap_cnt + 1'b1;
                    if (trig) overrun <= 1'b1;
                end
                DUMP: begin
                    if (trig) overrun <= 1'b1;
                    if (load) begin
                        tx_valid <= 1'b1;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt < BW'(4)) begin
                            tx_data <= hdr_byte;
                        end else begin
                            tx_data <= sample_byte;
                            if (ch_sel == CH_LAST) begin
                                ch_sel <= '0;
                                ptr    <= ptr + 1'b1;
                            end else begin
                                ch_sel <= ch_sel + 1'b1;
                            end
                        end
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 Parameter CH, default 1, meaning number of sensor channels captured per cycle (1..4).
REQ-002 Parameter DEPTH, default 1024, meaning samples stored per channel (power of two, 16..4096).
REQ-003 Parameter PRE, default 64, meaning pre-trigger samples retained (0 <= PRE < DEPTH).
REQ-004 Port clk, input, 1, meaning single clock for all logic.
REQ-005 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 Port arm, input, 1, meaning single-cycle request to start a capture.
REQ-007 Port trig, input, 1, meaning cipher-start pulse.
REQ-008 Port done, input, 1, meaning cipher-complete pulse.
REQ-009 Port sample_i, input, 8*CH, meaning packed decoded sensor values, channel 0 in bits [7:0], valid every cycle.
REQ-010 Port tx_ready, input, 1, meaning byte sink (UART transmitter) can accept a byte.
REQ-011 Port tx_valid, output, 1, meaning tx_data holds a byte to send.
REQ-012 Port tx_data, output, 8, meaning outgoing byte.
REQ-013 Port busy, output, 1, meaning high in any state except IDLE.
REQ-014 Port overrun, output, 1, meaning sticky flag: a trig was ignored.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED, CAPTURE and DUMP.
REQ-016 In IDLE, arm=1 SHALL move the FSM to ARMED next cycle, clear the fill count and clear overrun; all other inputs SHALL be ignored.
REQ-017 In ARMED, sample_i SHALL be written into a circular buffer every cycle and the fill count SHALL saturate at PRE.
REQ-018 In ARMED, trig=1 with fill count == PRE SHALL move the FSM to CAPTURE; the trigger-cycle sample SHALL be stored as logical index PRE.
REQ-019 In ARMED, trig=1 with fill count < PRE SHALL be ignored and SHALL set overrun.
REQ-020 CAPTURE SHALL store exactly DEPTH-PRE samples, counting the trigger cycle, then enter DUMP.
REQ-021 trig in CAPTURE or DUMP SHALL set overrun; arm outside IDLE SHALL be ignored.
REQ-022 DUMP SHALL emit a 4-byte header 0xA5, CH, DEPTH[15:8], DEPTH[7:0], followed by DEPTH*CH sample bytes.
REQ-023 Sample bytes SHALL be ordered oldest sample first (logical index 0 = earliest pre-trigger sample), channels 0..CH-1 within each index.
REQ-024 A byte SHALL transfer on a cycle where tx_valid && tx_ready; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-025 tx_valid SHALL assert no later than 2 cycles after DUMP entry and after each transfer; tx_ready held high SHALL sustain at least one byte per 2 cycles.
REQ-026 After the last byte transfers, the FSM SHALL return to IDLE next cycle with tx_valid=0.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH without a skipped or duplicated entry.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, tx_valid 0, tx_data 0x00, busy 0, overrun 0, pointers and counters 0.
REQ-029 rst asserted mid-CAPTURE or mid-DUMP SHALL abandon the transfer; buffer contents need not be cleared.

Configuration
REQ-030 With macro TRACE_MARKER_EN defined: in CAPTURE, a cycle with done=1 SHALL store 0xFF in every channel instead of sample_i, and live sample values of 0xFF SHALL be stored as 0xFE so the marker is unique.
REQ-031 Without TRACE_MARKER_EN: done SHALL be ignored and samples SHALL be stored unmodified.

Verification (CH=2, DEPTH=16, PRE=4)
REQ-032 Reset: rst pulse mid-DUMP -> tx_valid=0 and busy=0 in the same cycle; the next arm produces a full, correct dump.
REQ-033 Pre-trigger: arm; sample_i ch0 = cycle count n; trig on n=10 -> dump is A5 02 00 10, then ch0 indices 0..15 = 6..21.
REQ-034 Early trigger: arm then trig after 2 cycles -> overrun=1 and FSM stays ARMED; trig on a later cycle is accepted.
REQ-035 Back-pressure: tx_ready toggling randomly -> exactly 36 bytes transferred, none dropped or duplicated, tx_data stable while stalled.
REQ-036 Marker (TRACE_MARKER_EN): done at trigger+5, with ch1 input held at 0xFF -> both channels read 0xFF at logical index 9; every other ch1 byte reads 0xFE.
REQ-037 Wrap: 20 ARMED cycles before trig -> correct oldest-first ordering across the pointer wrap.
